// File: rtl/contador_pkg.sv
// Shared definitions for the programmable down counter/timer.
package contador_pkg;

  // Default counter width; the free-run borrow chain is one bit wider.
  localparam int WIDTH_DEF = 8;

  // Timer state encoding. 2'b11 is never entered and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/contador_desc.sv
// Programmable down counter/timer.
// Out of reset it free-runs downward through a WIDTH+1 bit borrow chain
// ({bout,out}). A load turns it into a countdown timer that either stops
// at zero (one-shot) or reloads the last loaded value (auto-reload),
// raising tc_pulse for one cycle each time a run reaches zero.
// Handshake: there is none; load and enable are level qualifiers sampled
// on every rising edge, load taking priority over enable.
module contador_desc
  import contador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             bout,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [WIDTH-1:0] CNT_ZERO  = '0;
  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   CHAIN_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             bout_q, bout_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   chain_dec;

  // Registers: asynchronous active-low reset, everything else on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      bout_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      bout_q   <= bout_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: load first, then per-state counting rules.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    bout_d    = bout_q;
    tc_d      = 1'b0;
    chain_dec = {bout_q, cnt_q} - CHAIN_ONE;

    if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      bout_d   = 1'b0;
      // Loading zero has nothing to count, so it parks without a pulse.
      state_d  = (load_val != CNT_ZERO) ? ST_RUN : ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            {bout_d, cnt_d} = chain_dec;
          end
        end
        ST_RUN: begin
          if (enable) begin
            if (cnt_q == CNT_ONE) begin
              // Pulse is registered so it lines up with out reading 0.
              cnt_d = CNT_ZERO;
              tc_d  = 1'b1;
              if (!auto_reload) begin
                state_d = ST_DONE;
              end
            end else if (cnt_q == CNT_ZERO) begin
              // Only reachable after an auto-reload terminal count; the
              // zero cycle is part of the period (reload_reg+1 cycles).
              cnt_d = reload_q;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          cnt_d = CNT_ZERO;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    out       = cnt_q;
    bout      = bout_q;
    tc_pulse  = tc_q;
    zero      = (cnt_q == CNT_ZERO);
    busy      = (state_q == ST_RUN);
    state_dbg = state_q;
  end

endmodule
